// File: rtl/image_stream_loader.sv
// ---------------------------------------------------------------------------
// image_stream_loader
//
// Front end of the CNN datapath. Accepts a raster-order pixel stream
// (channel-major, then row, then column) over a valid/ready handshake and
// packs one complete frame into the flat vector that feeds
// generated_cnn.input_image. The completed frame is held stable until the
// consumer acknowledges it, then the loader refills.
//
// Optional feature macro: IMG_LOADER_SOF_CHECK_EN
//   defined   : s_sof is checked against the pixel index. A mid-frame SOF
//               resyncs (pixel stored as pixel 0); a missing SOF on the first
//               pixel drops that pixel. Both raise sticky sof_error.
//   undefined : s_sof ignored, sof_error tied 0, frames delimited by count.
//
// Ports
//   clk          in   1           clock
//   rst          in   1           synchronous, active-high reset
//   s_pixel      in   PIXEL_WIDTH pixel data
//   s_valid      in   1           pixel present
//   s_ready      out  1           loader can accept a pixel
//   s_sof        in   1           start-of-frame marker, qualified by s_valid
//   input_image  out  FRAME_BITS  packed frame, pixel k at [k*PIXEL_WIDTH +: PIXEL_WIDTH]
//   frame_valid  out  1           input_image holds a complete, stable frame
//   frame_ack    in   1           consumer has taken the frame
//   frame_count  out  16          completed frames since reset (wraps)
//   sof_error    out  1           sticky framing error
// ---------------------------------------------------------------------------

// One pixel storage slot. Cleared by reset, loaded when its index is written;
// otherwise keeps its value, so a refill leaves older pixels in place until
// they are overwritten.
module image_stream_loader_slot #(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [PIXEL_WIDTH-1:0] d,
    output logic [PIXEL_WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (we)
            q <= d;
    end
endmodule

module image_stream_loader #(
    parameter int CHANNELS    = 1,
    parameter int HEIGHT      = 28,
    parameter int WIDTH       = 28,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [PIXEL_WIDTH-1:0]                           s_pixel,
    input  logic                                             s_valid,
    output logic                                             s_ready,
    input  logic                                             s_sof,
    output logic [CHANNELS*HEIGHT*WIDTH*PIXEL_WIDTH-1:0]     input_image,
    output logic                                             frame_valid,
    input  logic                                             frame_ack,
    output logic [15:0]                                      frame_count,
    output logic                                             sof_error
);
    localparam int NPIX       = CHANNELS * HEIGHT * WIDTH;
    localparam int IDX_W      = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [IDX_W-1:0]    wr_idx;
    logic [15:0]         count_next;
    logic                err_next;
    logic                accept;
    logic                store;

    logic [NPIX-1:0][PIXEL_WIDTH-1:0] pix;

    // Ready depends only on registered state (and rst), never on s_valid.
    assign s_ready     = (state == FILL) && !rst;
    assign accept      = s_valid && s_ready;
    assign frame_valid = (state == HOLD);
    assign input_image = pix;

    // Next-state / datapath control.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        count_next = frame_count;
        err_next   = sof_error;
        store      = 1'b0;
        wr_idx     = idx;
        case (state)
            FILL: begin
                if (accept) begin
`ifdef IMG_LOADER_SOF_CHECK_EN
                    if (idx == '0 && !s_sof) begin
                        // First pixel without SOF: drop it, stay at index 0.
                        err_next = 1'b1;
                    end else begin
                        store = 1'b1;
                        if (s_sof && idx != '0) begin
                            // Unexpected SOF: abandon partial frame, restart here.
                            err_next = 1'b1;
                            wr_idx   = '0;
                        end
                    end
`else
                    store = 1'b1;
`endif
                    if (store) begin
                        if (wr_idx == LAST_IDX) begin
                            idx_next   = '0;
                            state_next = HOLD;
                            count_next = frame_count + 16'd1;
                        end else begin
                            idx_next = wr_idx + IDX_W'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (frame_ack)
                    state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            idx         <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            frame_count <= count_next;
        end
    end

`ifdef IMG_LOADER_SOF_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            sof_error <= 1'b0;
        else
            sof_error <= err_next;
    end
`else
    logic unused_sof;
    logic unused_err;
    assign unused_sof = s_sof;
    assign unused_err = err_next;
    assign sof_error  = 1'b0;
`endif

    // Per-pixel storage; write enable decoded from the write index.
    for (genvar k = 0; k < NPIX; k++) begin : g_slot
        logic we;
        assign we = store && (wr_idx == IDX_W'(k));
        image_stream_loader_slot #(
            .PIXEL_WIDTH(PIXEL_WIDTH)
        ) u_slot (
            .clk (clk),
            .rst (rst),
            .we  (we),
            .d   (s_pixel),
            .q   (pix[k])
        );
    end
endmodule

// File: tb/tb_image_stream_loader.sv
// Scoreboarded bench for image_stream_loader: a driver feeds random pixel
// streams, a frame-level model predicts each completed frame and pushes it on
// a queue, and a negedge monitor compares handshake/status every cycle and
// pops/compares frames whenever frame_valid rises.
module tb_image_stream_loader;
    localparam int CH = 1, HT = 28, WD = 28, PW = 8;
    localparam int NPIX = CH * HT * WD;
    localparam int FB   = NPIX * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] s_pixel;
    logic          s_valid;
    logic          s_ready;
    logic          s_sof;
    logic [FB-1:0] input_image;
    logic          frame_valid;
    logic          frame_ack;
    logic [15:0]   frame_count;
    logic          sof_error;

    image_stream_loader #(
        .CHANNELS(CH), .HEIGHT(HT), .WIDTH(WD), .PIXEL_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid),
        .s_ready(s_ready), .s_sof(s_sof), .input_image(input_image),
        .frame_valid(frame_valid), .frame_ack(frame_ack),
        .frame_count(frame_count), .sof_error(sof_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Frame-level reference model
    typedef struct {
        logic [FB-1:0] img;
        logic [15:0]   cnt;
    } frame_t;
    frame_t      exp_q[$];
    logic [7:0]  model_img[NPIX];
    int          model_idx;
    bit          model_hold;
    logic [15:0] model_count;
    bit          model_err;
    bit          mon_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_img(input string nm, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            for (int k = 0; k < NPIX; k++)
                if (act[k*PW +: PW] !== exp[k*PW +: PW]) begin
                    $display("FAIL %s: pixel %0d got %0h expected %0h at %0t",
                             nm, k, act[k*PW +: PW], exp[k*PW +: PW], $time);
                    break;
                end
        end
    endtask

    function automatic logic [FB-1:0] model_frame();
        logic [FB-1:0] f;
        for (int k = 0; k < NPIX; k++) f[k*PW +: PW] = model_img[k];
        return f;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NPIX; k++) model_img[k] = 8'h00;
        model_idx   = 0;
        model_hold  = 0;
        model_count = 16'd0;
        model_err   = 0;
    endfunction

    // Apply one accepted pixel to the model.
    function automatic void model_accept(input logic [7:0] p, input bit sof);
        int k;
        k = model_idx;
`ifdef IMG_LOADER_SOF_CHECK_EN
        if (model_idx == 0 && !sof) begin
            model_err = 1;
            return;
        end
        if (sof && model_idx != 0) begin
            model_err = 1;
            k = 0;
        end
`endif
        model_img[k] = p;
        if (k == NPIX - 1) begin
            model_count = model_count + 16'd1;
            model_idx   = 0;
            model_hold  = 1;
            exp_q.push_back('{img: model_frame(), cnt: model_count});
        end else begin
            model_idx = k + 1;
        end
    endfunction

    // Monitor: per-cycle status checks plus frame scoreboard.
    bit     fv_prev = 0;
    frame_t held;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("s_ready", 32'(s_ready), 32'(!model_hold && !rst));
            chk("frame_valid", 32'(frame_valid), 32'(model_hold));
            chk("frame_count", 32'(frame_count), 32'(model_count));
            chk("sof_error", 32'(sof_error), 32'(model_err));
            if (frame_valid === 1'b1 && !fv_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(1), 32'(0));
                end else begin
                    held = exp_q.pop_front();
                    chk_img("frame_image", input_image, held.img);
                    chk("frame_tag_count", 32'(frame_count), 32'(held.cnt));
                end
            end else if (frame_valid === 1'b1 && fv_prev) begin
                chk_img("hold_stable", input_image, held.img);
            end
            fv_prev = (frame_valid === 1'b1);
        end
    end

    // Driver tasks: each starts and ends 1 time unit after a rising edge.
    task automatic put(input logic [7:0] p, input bit sof, input int gap);
        s_valid = 0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1; s_pixel = p; s_sof = sof;
        @(posedge clk);
        model_accept(p, sof);
        #1;
        s_valid = 0; s_sof = 0;
    endtask

    function automatic int rgap();
        return ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 2)) : 0;
    endfunction

    // Stream until the model reports a completed frame; returns accepts used.
    task automatic send_frame(input bit ramp, input bit gaps, output int n);
        logic [7:0] p;
        n = 0;
        while (!model_hold && n < 4 * NPIX) begin
            p = ramp ? 8'(model_idx) : 8'($urandom);
            put(p, model_idx == 0, gaps ? rgap() : 0);
            n++;
        end
        if (!model_hold) chk("frame_completion", 32'(0), 32'(1));
    endtask

    task automatic ack(input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        frame_ack = 1;
        @(posedge clk);
        model_hold = 0;
        #1;
        frame_ack = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1;
        repeat (cycles) @(posedge clk);
        model_reset();
        #1;
        rst = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        logic [FB-1:0] snap;
        rst = 1; s_pixel = '0; s_valid = 0; s_sof = 0; frame_ack = 0;
        model_reset();

        // 1: reset
        do_reset(2);
        mon_en = 1;
        @(negedge clk);
        chk_img("reset_image", input_image, '0);
        @(posedge clk); #1;

        // 2: ramp frame, back-to-back
        send_frame(1, 0, n);
        chk("ramp_accepts", 32'(n), 32'(NPIX));
        @(negedge clk);
        chk("ramp_fv_next_cycle", 32'(frame_valid), 32'(1));
        chk("ramp_byte0", 32'(input_image[7:0]), 32'h00);
        chk("ramp_byte1", 32'(input_image[15:8]), 32'h01);
        chk("ramp_byte_last", 32'(input_image[FB-1 -: 8]), 32'h0F);
        chk("ramp_count", 32'(frame_count), 32'd1);
        snap = input_image;
        @(posedge clk); #1;

        // 3: s_valid asserted during hold for 50 cycles -> nothing accepted
        s_valid = 1; s_pixel = 8'hEE; s_sof = 1;
        repeat (50) begin @(posedge clk); #1; end
        s_valid = 0; s_sof = 0;
        chk_img("hold_no_accept", input_image, snap);
        ack(0);
        @(negedge clk);
        chk("ack_fv_drop", 32'(frame_valid), 32'(0));
        chk("ack_ready", 32'(s_ready), 32'(1));
        @(posedge clk); #1;

        // ack while filling is ignored
        frame_ack = 1; @(posedge clk); #1; frame_ack = 0;

        // 4: three random frames with ~30% idle cycles
        for (int f = 0; f < 3; f++) begin
            send_frame(0, 1, n);
            ack($urandom_range(0, 5));
        end

        // 5: reset after 400 pixels, then a fresh frame
        for (int i = 0; i < 400; i++) put(8'($urandom), i == 0, rgap());
        do_reset(1);
        @(negedge clk);
        chk_img("midframe_reset_image", input_image, '0);
        @(posedge clk); #1;
        send_frame(0, 1, n);
        chk("post_reset_accepts", 32'(n), 32'(NPIX));
        ack(2);

`ifdef IMG_LOADER_SOF_CHECK_EN
        // 6: mid-frame SOF resync
        do_reset(1);
        for (int i = 0; i < 100; i++) put(8'($urandom), i == 0, 0);
        put(8'hA5, 1, 0);
        @(negedge clk);
        chk("resync_err", 32'(sof_error), 32'(1));
        chk("resync_pixel0", 32'(input_image[7:0]), 32'hA5);
        @(posedge clk); #1;
        n = 0;
        while (!model_hold && n < 2 * NPIX) begin put(8'($urandom), 0, 0); n++; end
        chk("resync_remaining", 32'(n), 32'(NPIX - 1));
        ack(1);
        // first pixel without SOF is dropped
        do_reset(1);
        put(8'h77, 0, 0);
        @(negedge clk);
        chk("drop_err", 32'(sof_error), 32'(1));
        chk("drop_not_stored", 32'(input_image[7:0]), 32'h00);
        @(posedge clk); #1;
        send_frame(0, 0, n);
        chk("after_drop_accepts", 32'(n), 32'(NPIX));
        ack(0);
`else
        // SOF ignored: stray SOF mid-frame changes nothing
        for (int i = 0; i < NPIX; i++) put(8'($urandom), (i % 97) == 50, rgap());
        @(negedge clk);
        chk("sof_ignored_fv", 32'(frame_valid), 32'(1));
        chk("sof_ignored_err", 32'(sof_error), 32'(0));
        @(posedge clk); #1;
        ack(0);
`endif

        repeat (3) begin @(posedge clk); #1; end
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
